// File: rtl/mux_n_1_arb_if.sv
// mux_n_1_arb_if: channel inputs, select controls and registered output handshake
interface mux_n_1_arb_if #(
  parameter int N = 4,
  parameter int WIDTH = 8,
  parameter int SELW = 2
);
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic mode;
  logic [SELW-1:0] sel;
  logic [WIDTH-1:0] out_data;
  logic [SELW-1:0] out_chan;
  logic out_valid;
  logic out_ready;
  modport master(
    output in_data, in_valid, mode, sel, out_ready,
    input in_ready, out_data, out_chan, out_valid
  );
  modport slave(
    input in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/mux_n_1_arb.sv
// mux_n_1_arb: N:1 mux with fixed-select or round-robin grant into a single output register
module mux_n_1_arb #(
  parameter int N = 4,
  parameter int WIDTH = 8,
  parameter int SELW = 2
) (
  input logic clk,
  input logic rst_n,
  mux_n_1_arb_if.slave bus
);
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] rr_idx;
  logic [SELW-1:0] c;
  logic [SELW-1:0] grant_idx;
  logic sel_valid;
  logic grant_valid;
  logic load;
  logic [WIDTH-1:0] gdata;
  // round-robin search from ptr+1; scanning farthest-first lets the nearest valid channel win
  always_comb begin
    rr_idx = '0;
    c = '0;
    sel_valid = 1'b0;
    for (int k = N; k >= 1; k--) begin
      c = SELW'((int'(ptr) + k) % N);
      if (bus.in_valid[c]) rr_idx = c;
    end
    for (int i = 0; i < N; i++)
      if (bus.sel == SELW'(i)) sel_valid = bus.in_valid[i];
  end
  // grant, load decision and one-hot accept strobe
  always_comb begin
    grant_idx = bus.mode ? rr_idx : bus.sel;
    grant_valid = bus.mode ? |bus.in_valid : sel_valid;
    load = (!bus.out_valid || bus.out_ready) && grant_valid;
    bus.in_ready = (load && rst_n) ? N'(1) << grant_idx : '0;
    gdata = '0;
    for (int i = 0; i < N; i++)
      if (grant_idx == SELW'(i)) gdata = bus.in_data[i*WIDTH +: WIDTH];
  end
  // output register: capture on load, drain when consumed with nothing new, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_data <= '0;
      bus.out_chan <= '0;
      bus.out_valid <= 1'b0;
    end else if (load) begin
      bus.out_data <= gdata;
      bus.out_chan <= grant_idx;
      bus.out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
  // round-robin pointer follows the last grant in arbitration mode only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= SELW'(N - 1);
    else if (load && bus.mode) ptr <= grant_idx;
  end
endmodule

// File: tb/tb_mux_n_1_arb.sv
// tb_mux_n_1_arb: directed scenarios plus a per-cycle reference model comparison
module tb_mux_n_1_arb;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  mux_n_1_arb_if #(.N(N), .WIDTH(W), .SELW(2)) bus ();
  mux_n_1_arb #(.N(N), .WIDTH(W), .SELW(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  logic [7:0] m_data = '0;
  logic [1:0] m_chan = '0;
  logic m_valid = 1'b0;
  int m_ptr = N - 1;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic int m_gidx();
    if (!bus.mode) return int'(bus.sel);
    for (int k = 1; k <= N; k++)
      if (bus.in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return 0;
  endfunction
  function automatic bit m_load();
    bit gv;
    gv = bus.mode ? (bus.in_valid != 0) : bus.in_valid[bus.sel];
    return (!m_valid || bus.out_ready) && gv;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data <= '0;
      m_chan <= '0;
      m_valid <= 1'b0;
      m_ptr <= N - 1;
    end else if (m_load()) begin
      m_data <= bus.in_data[m_gidx()*W +: W];
      m_chan <= 2'(m_gidx());
      m_valid <= 1'b1;
      if (bus.mode) m_ptr <= m_gidx();
    end else if (bus.out_ready) begin
      m_valid <= 1'b0;
    end
  end
  always @(negedge clk) begin
    check("model in_ready", 32'(bus.in_ready), (rst_n && m_load()) ? 32'(1) << m_gidx() : 32'd0);
    check("model out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("model out_data", 32'(bus.out_data), 32'(m_data));
    check("model out_chan", 32'(bus.out_chan), 32'(m_chan));
  end
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  localparam logic [31:0] STD = 32'h44332211;
  initial begin
    bus.in_data = STD;
    bus.in_valid = 4'b1111;
    bus.mode = 1'b1;
    bus.sel = '0;
    bus.out_ready = 1'b1;
    cyc();
    cyc();
    check("reset out_valid", 32'(bus.out_valid), 0);
    check("reset out_data", 32'(bus.out_data), 0);
    check("reset out_chan", 32'(bus.out_chan), 0);
    check("reset in_ready", 32'(bus.in_ready), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("rr fair out_chan", 32'(bus.out_chan), 32'(i % 4));
      check("rr fair out_valid", 32'(bus.out_valid), 1);
    end
    bus.in_valid = 4'b0010;
    cyc();
    check("set ptr out_chan", 32'(bus.out_chan), 1);
    bus.in_valid = 4'b1010;
    #1 check("rr 1010 first in_ready", 32'(bus.in_ready), 32'b1000);
    cyc();
    check("rr 1010 chan a", 32'(bus.out_chan), 3);
    #1 check("rr 1010 second in_ready", 32'(bus.in_ready), 32'b0010);
    cyc();
    check("rr 1010 chan b", 32'(bus.out_chan), 1);
    cyc();
    check("rr 1010 chan c", 32'(bus.out_chan), 3);
    check("rr 1010 data c", 32'(bus.out_data), 32'h44);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = $urandom;
      bus.in_valid = 4'($urandom_range(1, 15));
      bus.mode = 1'($urandom);
      bus.sel = 2'($urandom);
      #1 check("stall in_ready", 32'(bus.in_ready), 0);
      cyc();
      check("stall out_data", 32'(bus.out_data), 32'h44);
      check("stall out_chan", 32'(bus.out_chan), 3);
      check("stall out_valid", 32'(bus.out_valid), 1);
    end
    bus.in_data = STD;
    bus.mode = 1'b0;
    bus.sel = 2'd0;
    bus.in_valid = 4'b0001;
    bus.out_ready = 1'b1;
    #1 check("unstall in_ready", 32'(bus.in_ready), 32'b0001);
    cyc();
    check("unstall out_data", 32'(bus.out_data), 32'h11);
    check("unstall out_chan", 32'(bus.out_chan), 0);
    check("unstall out_valid", 32'(bus.out_valid), 1);
    bus.sel = 2'd1;
    #1 check("sel invalid in_ready", 32'(bus.in_ready), 0);
    cyc();
    check("drain out_valid", 32'(bus.out_valid), 0);
    bus.sel = 2'd2;
    bus.in_valid = 4'b0100;
    #1 check("fixed sel2 in_ready", 32'(bus.in_ready), 32'b0100);
    cyc();
    check("fixed sel2 out_data", 32'(bus.out_data), 32'h33);
    check("fixed sel2 out_chan", 32'(bus.out_chan), 2);
    check("fixed sel2 out_valid", 32'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1 check("async rst out_valid", 32'(bus.out_valid), 0);
    check("async rst out_data", 32'(bus.out_data), 0);
    check("async rst in_ready", 32'(bus.in_ready), 0);
    cyc();
    bus.mode = 1'b1;
    bus.in_valid = 4'b1111;
    rst_n = 1'b1;
    cyc();
    check("post rst out_chan", 32'(bus.out_chan), 0);
    check("post rst out_valid", 32'(bus.out_valid), 1);
    for (int i = 0; i < 60; i++) begin
      bus.in_data = $urandom;
      bus.in_valid = 4'($urandom);
      bus.mode = 1'($urandom);
      bus.sel = 2'($urandom);
      bus.out_ready = 1'($urandom);
      cyc();
    end
    @(negedge clk);
    #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
